// File: rtl/div_mod_pkg.sv
// div_mod_pkg: shared widths, mode encodings, saturation limits and FSM state
// type for the signed divide/modulo block.
package div_mod_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 16;
  localparam int RESULT_W   = 17;

  localparam logic MODE_QUOT = 1'b0;
  localparam logic MODE_REM  = 1'b1;

  // 17-bit two's complement limits: +65535 and -65536.
  localparam logic [RESULT_W-1:0] Q_MAX = 17'h0FFFF;
  localparam logic [RESULT_W-1:0] Q_MIN = 17'h10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_core_unsigned.sv
// div_core_unsigned: 32/16 unsigned restoring divider, one quotient bit per
// cycle, MSB first.
//   clk, reset     : clock, synchronous active-low reset
//   start          : load operands and begin (ignored while reset is low)
//   dividend       : 32-bit unsigned dividend
//   divisor        : 16-bit unsigned divisor
//   done           : high during the cycle whose closing edge runs the
//                    last (32nd) iteration
//   quotient       : 32-bit quotient, final after the last iteration
//   remainder      : 16-bit remainder, final after the last iteration
import div_mod_pkg::*;

module div_core_unsigned (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder
);

  // quo_q starts as the dividend and shifts left; quotient bits fill in
  // from the bottom while dividend bits leave from the top.
  logic [DIVIDEND_W-1:0] quo_q;
  logic [DIVISOR_W-1:0]  rem_q;
  logic [DIVISOR_W-1:0]  dvs_q;
  logic [4:0]            count_q;
  logic                  busy_q;

  logic [DIVISOR_W:0]    trial;
  logic [DIVISOR_W-1:0]  diff;
  logic                  fits;

  // The 17-bit trial remainder is {remainder, next dividend bit}. When it
  // fits, trial - divisor < divisor, so the low 16 bits of the
  // subtraction are exact.
  assign trial = {rem_q, quo_q[DIVIDEND_W-1]};
  assign fits  = (trial >= {1'b0, dvs_q});
  assign diff  = trial[DIVISOR_W-1:0] - dvs_q;

  assign done      = busy_q && (count_q == 5'd31);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      quo_q   <= dividend;
      rem_q   <= '0;
      dvs_q   <= divisor;
      count_q <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      rem_q   <= fits ? diff : trial[DIVISOR_W-1:0];
      quo_q   <= {quo_q[DIVIDEND_W-2:0], fits};
      count_q <= count_q + 5'd1;
      if (count_q == 5'd31) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/div_mod_top_level.sv
// div_mod_top_level: sequential signed divider returning the truncated
// quotient (saturated to 17 bits) or the remainder of dividend / divisor.
//   clk, reset    : clock, synchronous active-low reset
//   dividend      : 32-bit signed dividend
//   divisor       : 16-bit signed divisor
//   mode          : 0 = quotient, 1 = remainder
//   valid_input   : request strobe, accepted only in IDLE
//   valid_output  : one-cycle pulse when final_output is updated
//   final_output  : 17-bit signed result, held until the next result
//   dbg_state     : current FSM state, for observation only
// Handshake: a request is accepted on any rising edge where valid_input=1
// and the FSM is IDLE; requests in BUSY/DONE are dropped. The result
// appears 33 edges after acceptance with valid_output high for one cycle.
import div_mod_pkg::*;

module div_mod_top_level (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  input  logic                  mode,
  input  logic                  valid_input,
  output logic                  valid_output,
  output logic [RESULT_W-1:0]   final_output,
  output state_t                dbg_state
);

  state_t state;
  logic   mode_r;
  logic   dividend_neg;
  logic   divisor_neg;
  logic   divisor_zero;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend_mag;
  logic [DIVISOR_W-1:0]  divisor_mag;
  logic                  core_done;
  logic [DIVIDEND_W-1:0] core_quot;
  logic [DIVISOR_W-1:0]  core_rem;

  logic                  quot_neg;
  logic [RESULT_W-1:0]   quot_res;
  logic [RESULT_W-1:0]   rem_res;
  logic [RESULT_W-1:0]   result;

  assign dbg_state = state;
  assign start     = (state == IDLE) && valid_input;

  // The most negative dividend has magnitude 2^31, which still fits the
  // 32-bit unsigned magnitude; likewise -32768 for the divisor.
  assign dividend_mag = dividend[DIVIDEND_W-1] ? (~dividend + 32'd1) : dividend;
  assign divisor_mag  = divisor[DIVISOR_W-1]  ? (~divisor + 16'd1)  : divisor;

  div_core_unsigned u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend_mag),
    .divisor   (divisor_mag),
    .done      (core_done),
    .quotient  (core_quot),
    .remainder (core_rem)
  );

  assign quot_neg = dividend_neg ^ divisor_neg;

  // Sign correction and saturation. Negating a zero magnitude wraps to zero,
  // so a zero result is never negative. A negative magnitude of exactly
  // 65536 negates to 17'h10000, which is Q_MIN.
  always_comb begin
    quot_res = '0;
    rem_res  = '0;
    result   = '0;
    if (quot_neg) begin
      if (core_quot > 32'd65536) quot_res = Q_MIN;
      else                       quot_res = ~core_quot[RESULT_W-1:0] + 17'd1;
    end else begin
      if (core_quot > 32'd65535) quot_res = Q_MAX;
      else                       quot_res = core_quot[RESULT_W-1:0];
    end
    rem_res = dividend_neg ? (~{1'b0, core_rem} + 17'd1) : {1'b0, core_rem};
    if (divisor_zero) begin
      if (mode_r == MODE_REM) result = '0;
      else                    result = dividend_neg ? Q_MIN : Q_MAX;
    end else begin
      result = (mode_r == MODE_REM) ? rem_res : quot_res;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      valid_output <= 1'b0;
      final_output <= '0;
      mode_r       <= 1'b0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      divisor_zero <= 1'b0;
    end else begin
      valid_output <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_input) begin
            mode_r       <= mode;
            dividend_neg <= dividend[DIVIDEND_W-1];
            divisor_neg  <= divisor[DIVISOR_W-1];
            divisor_zero <= (divisor == '0);
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (core_done) state <= DONE;
        end
        DONE: begin
          final_output <= result;
          valid_output <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_mod_top_level.sv
module tb_div_mod_top_level;
  import div_mod_pkg::*;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        mode;
  logic        valid_input;
  logic        valid_output;
  logic [16:0] final_output;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [15:0] b;
    logic        m;
    logic [16:0] exp;
  } vec_t;

  div_mod_top_level dut (
    .clk          (clk),
    .reset        (reset),
    .dividend     (dividend),
    .divisor      (divisor),
    .mode         (mode),
    .valid_input  (valid_input),
    .valid_output (valid_output),
    .final_output (final_output),
    .dbg_state    (dbg_state)
  );

  // Driver: called #1 after a rising edge. Presents a request for one edge
  // (the accept edge E0), then scrambles the operands.
  task automatic issue(input logic [31:0] a, input logic [15:0] b, input logic m);
    dividend    = a;
    divisor     = b;
    mode        = m;
    valid_input = 1'b1;
    @(posedge clk);
    #1;
    valid_input = 1'b0;
    dividend    = $urandom();
    divisor     = 16'($urandom());
    mode        = ~m;
  endtask

  // Driver: waits up to 40 edges for valid_output; lat = edges after E0, -1 on timeout.
  task automatic wait_result(output int lat, output logic [16:0] res);
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (valid_output) begin
        lat = i;
        res = final_output;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset       = 1'b0;
    valid_input = 1'b1;
    dividend    = 32'd80;
    divisor     = 16'd3;
    mode        = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (valid_output !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_output); end
    checks++;
    if (final_output !== 17'h0) begin errors++; $display("FAIL reset_output: got %h expected 00000", final_output); end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
    valid_input = 1'b0;
    reset       = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL reset_release_state: got %0d expected %0d", dbg_state, IDLE); end
  endtask

  task automatic test_basic;
    vec_t v[2];
    int lat;
    logic [16:0] res;
    v = '{'{32'd80, 16'd3, 1'b1, 17'd2}, '{32'd80, 16'd3, 1'b0, 17'd26}};
    for (int k = 0; k < 2; k++) begin
      issue(v[k].a, v[k].b, v[k].m);
      wait_result(lat, res);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL basic_latency[%0d]: got %0d expected 33", k, lat); end
      checks++;
      if (res !== v[k].exp) begin errors++; $display("FAIL basic_value[%0d]: got %h expected %h", k, res, v[k].exp); end
      @(posedge clk);
      #1;
      checks++;
      if (valid_output !== 1'b0) begin errors++; $display("FAIL basic_pulse_width[%0d]: got %b expected 0", k, valid_output); end
      checks++;
      if (final_output !== v[k].exp) begin errors++; $display("FAIL basic_hold[%0d]: got %h expected %h", k, final_output, v[k].exp); end
    end
  endtask

  task automatic test_signed;
    vec_t v[8];
    int lat;
    logic [16:0] res;
    v = '{'{32'(-80), 16'd3,     1'b0, 17'(-26)},
          '{32'(-80), 16'd3,     1'b1, 17'(-2)},
          '{32'd80,   16'(-3),   1'b0, 17'(-26)},
          '{32'd80,   16'(-3),   1'b1, 17'd2},
          '{32'(-80), 16'(-3),   1'b0, 17'd26},
          '{32'(-80), 16'(-3),   1'b1, 17'(-2)},
          '{32'd0,    16'd7,     1'b0, 17'd0},
          '{32'd0,    16'd7,     1'b1, 17'd0}};
    for (int k = 0; k < 8; k++) begin
      issue(v[k].a, v[k].b, v[k].m);
      wait_result(lat, res);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL signed_latency[%0d]: got %0d expected 33", k, lat); end
      checks++;
      if (res !== v[k].exp) begin errors++; $display("FAIL signed_value[%0d]: got %h expected %h", k, res, v[k].exp); end
    end
  endtask

  task automatic test_saturation;
    vec_t v[4];
    int lat;
    logic [16:0] res;
    v = '{'{32'd1000000,   16'd2,      1'b0, 17'h0FFFF},
          '{32'(-1000000), 16'd2,      1'b0, 17'h10000},
          '{32'h80000000,  16'hFFFF,   1'b0, 17'h0FFFF},
          '{32'h7FFFFFFF,  16'h8000,   1'b1, 17'd32767}};
    for (int k = 0; k < 4; k++) begin
      issue(v[k].a, v[k].b, v[k].m);
      wait_result(lat, res);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL sat_latency[%0d]: got %0d expected 33", k, lat); end
      checks++;
      if (res !== v[k].exp) begin errors++; $display("FAIL sat_value[%0d]: got %h expected %h", k, res, v[k].exp); end
    end
  endtask

  task automatic test_div_zero;
    vec_t v[3];
    int lat;
    logic [16:0] res;
    v = '{'{32'd80,   16'd0, 1'b0, 17'h0FFFF},
          '{32'(-80), 16'd0, 1'b0, 17'h10000},
          '{32'd80,   16'd0, 1'b1, 17'd0}};
    for (int k = 0; k < 3; k++) begin
      issue(v[k].a, v[k].b, v[k].m);
      wait_result(lat, res);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL divzero_latency[%0d]: got %0d expected 33", k, lat); end
      checks++;
      if (res !== v[k].exp) begin errors++; $display("FAIL divzero_value[%0d]: got %h expected %h", k, res, v[k].exp); end
    end
  endtask

  // 1000/7 in mode 0 = 142; second request at E10 (99/2 rem) must be dropped;
  // request at E34 (-1000/7 rem = -6) must be accepted.
  task automatic test_back_to_back;
    int pulses = 0;
    int first_at = -1;
    int second_at = -1;
    logic [16:0] first_val = 'x;
    logic [16:0] second_val = 'x;
    logic stable = 1'b1;
    issue(32'd1000, 16'd7, 1'b0);
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) begin
        valid_input = 1'b0;
        checks++;
        if (dbg_state !== BUSY) begin errors++; $display("FAIL busy_state: got %0d expected %0d", dbg_state, BUSY); end
      end
      if (i == 34) valid_input = 1'b0;
      if (valid_output) begin
        pulses++;
        if (pulses == 1) begin first_at = i; first_val = final_output; end
        if (pulses == 2) begin second_at = i; second_val = final_output; end
      end
      if (i > 33 && i < 67 && final_output !== 17'd142) stable = 1'b0;
      if (i == 9) begin
        dividend    = 32'd99;
        divisor     = 16'd2;
        mode        = 1'b1;
        valid_input = 1'b1;
      end
      if (valid_output && pulses == 1) begin
        dividend    = 32'(-1000);
        divisor     = 16'd7;
        mode        = 1'b1;
        valid_input = 1'b1;
      end
    end
    valid_input = 1'b0;
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL b2b_pulse_count: got %0d expected 2", pulses); end
    checks++;
    if (first_at !== 33) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 33", first_at); end
    checks++;
    if (first_val !== 17'd142) begin errors++; $display("FAIL b2b_first_value: got %h expected %h", first_val, 17'd142); end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL b2b_hold: got %b expected 1", stable); end
    checks++;
    if (second_at !== 67) begin errors++; $display("FAIL b2b_second_latency: got %0d expected 67", second_at); end
    checks++;
    if (second_val !== 17'h1FFFA) begin errors++; $display("FAIL b2b_second_value: got %h expected 1fffa", second_val); end
  endtask

  task automatic test_reset_abort;
    int seen = 0;
    int lat;
    logic [16:0] res;
    issue(32'd80, 16'd3, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    checks++;
    if (final_output !== 17'h0) begin errors++; $display("FAIL abort_output: got %h expected 00000", final_output); end
    checks++;
    if (dbg_state !== IDLE) begin errors++; $display("FAIL abort_state: got %0d expected %0d", dbg_state, IDLE); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid_output) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses expected 0", seen); end
    issue(32'(-80), 16'd3, 1'b1);
    wait_result(lat, res);
    checks++;
    if (lat !== 33) begin errors++; $display("FAIL abort_next_latency: got %0d expected 33", lat); end
    checks++;
    if (res !== 17'h1FFFE) begin errors++; $display("FAIL abort_next_value: got %h expected 1fffe", res); end
  endtask

  initial begin
    reset       = 1'b0;
    valid_input = 1'b0;
    dividend    = '0;
    divisor     = '0;
    mode        = 1'b0;
    @(negedge clk);
    test_reset;
    test_basic;
    test_signed;
    test_saturation;
    test_div_zero;
    test_back_to_back;
    test_reset_abort;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_mod_top_level.md
# div_mod_top_level

Sequential signed integer divider that computes either the truncated quotient or the remainder of a 32-bit signed dividend by a 16-bit signed divisor. The result is a 17-bit signed value. It is a standalone arithmetic block with a single-transaction valid-in/valid-out handshake, for use in a datapath that issues one division at a time.

## Interface
Parameters: none (widths are fixed constants in the package).
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on clk rising edge)
- dividend  input  32  signed dividend, two's complement
- divisor  input  16  signed divisor, two's complement
- mode  input  1  operation select: 0 = quotient, 1 = remainder
- valid_input  input  1  request strobe; operands and mode are captured on the accepting edge
- valid_output  output  1  one-cycle pulse marking final_output as a new result
- final_output  output  17  signed result; holds its value until the next result

## Operation
- States:
  - IDLE: waits for a request.
  - BUSY: runs 32 iterations.
  - DONE: takes one cycle to correct signs and saturate.
- IDLE -> BUSY: on an edge where valid_input=1. That edge latches dividend, divisor, mode, both operand signs and both magnitudes.
  - Magnitudes are unsigned: 32 bits for the dividend (|-2^31| = 2^31 is representable) and 16 bits for the divisor.
- BUSY: unsigned restoring division, one quotient bit per cycle, MSB first, with a 17-bit partial remainder. It runs 32 cycles, then moves to DONE.
- DONE -> IDLE: loads final_output, pulses valid_output, and returns to IDLE.
- valid_input is ignored in BUSY and DONE. There is no queueing and no back-pressure signal.
- Sign rules (C semantics):
  - The quotient truncates toward zero and is negative iff the operand signs differ.
  - The remainder takes the sign of the dividend.
  - A zero result is never negative.
- Quotient width: the quotient is saturated to the 17-bit signed range [-65536, +65535].
  - Example: -2^31 / -1 gives +65535.
- Remainder width: |remainder| < |divisor| <= 32768, so the remainder always fits and is sign-extended to 17 bits.
- Divide by zero:
  - mode 0: final_output = +65535 if dividend >= 0, otherwise -65536.
  - mode 1: final_output = 0.
  - Timing and handshake are unchanged.

## Timing
- Accept edge E0, iteration edges E1..E32, result edge E33.
  - valid_output is high for exactly the cycle between E33 and E34.
  - final_output changes only at E33.
- Latency is 33 cycles from accept to result. Maximum throughput is one request every 34 cycles.
  - A valid_input sampled at E34, with the state back in IDLE, is accepted.
- Reset values: valid_output=0, final_output=0, state=IDLE, all internal registers 0.
- Reset mid-operation aborts the current division. No valid_output is produced for it.
- Reset has priority over valid_input on the same edge.
- Operand inputs may change freely after E0 without affecting the result.

## Structure
- Package div_mod_pkg:
  - DIVIDEND_W=32, DIVISOR_W=16, RESULT_W=17
  - MODE_QUOT=0, MODE_REM=1
  - Saturation constants Q_MAX=+65535, Q_MIN=-65536
  - State enum {IDLE, BUSY, DONE}
- Sub-module div_core_unsigned: 32/16 unsigned iterative restoring divider with start/done, producing a 32-bit quotient and a 16-bit remainder.
- The top level holds the handshake FSM, sign capture, magnitude conversion, sign correction, saturation and the mode mux.

## Test plan
- Reset held low for 5 cycles, then released; dividend=80, divisor=3, mode=1, valid_input pulsed -> valid_output pulses exactly 33 cycles after accept with final_output=2. Same with mode=0 -> 26.
- Signed cases, each checked in both modes:
  - -80/3 -> quotient -26, remainder -2
  - 80/-3 -> quotient -26, remainder 2
  - -80/-3 -> quotient 26, remainder -2
  - 0/7 -> quotient 0, remainder 0
- Saturation cases:
  - 1000000/2 in mode 0 -> 65535
  - -1000000/2 in mode 0 -> -65536
  - -2147483648/-1 in mode 0 -> 65535
  - 2147483647/-32768 in mode 1 -> 32767
- Divide by zero:
  - 80/0 in mode 0 -> 65535
  - -80/0 in mode 0 -> -65536
  - 80/0 in mode 1 -> 0
  - In every case valid_output fires at the normal latency.
- Handshake while busy: second valid_input with different operands at E10 -> ignored, one valid_output with the first result, final_output then stable; a new request at E34 is accepted.
- Reset driven low at E15 of an operation -> no valid_output, final_output=0; the next request completes correctly.
